// File: rtl/dmem_access_unit.sv
// dmem_access_unit: byte-lane steering, load extension and ready handshake to a wait-stated data memory.
// Optional MEM_TIMEOUT_EN: aborts a wait state after TIMEOUT_CYCLES cycles without mem_ready.
`default_nettype none

module dmem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  // The wait counter is 5 bits wide, so the abort threshold must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 31) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 1..31");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_WR_WAIT = 3'd2,
    S_DONE    = 3'd3,
    S_ERR     = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [1:0]  lo_q, lo_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;

  logic        is_load, is_store, misaligned;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic        in_wait;
  logic        timeout;

  assign in_wait = (state_q == S_RD_WAIT) || (state_q == S_WR_WAIT);

`ifdef MEM_TIMEOUT_EN
  localparam logic [4:0] TO_LAST = 5'(TIMEOUT_CYCLES - 1);
  logic [4:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!in_wait)
      cnt_d = '0;
    else if (!mem_ready)
      cnt_d = cnt_q + 5'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign timeout = in_wait && !mem_ready && (cnt_q == TO_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    misaligned = 1'b0;
    st_be      = 4'b0000;
    st_data    = 32'h0;
    case (op)
      OP_LB, OP_LBU: is_load = 1'b1;
      OP_LH, OP_LHU: begin is_load = 1'b1; misaligned = addr[0]; end
      OP_LW:         begin is_load = 1'b1; misaligned = (addr[1:0] != 2'b00); end
      OP_SB: begin
        is_store = 1'b1;
        st_be    = 4'b0001 << addr[1:0];
        st_data  = {4{wdata[7:0]}};
      end
      OP_SH: begin
        is_store   = 1'b1;
        misaligned = addr[0];
        st_be      = addr[1] ? 4'b1100 : 4'b0011;
        st_data    = {2{wdata[15:0]}};
      end
      OP_SW: begin
        is_store   = 1'b1;
        misaligned = (addr[1:0] != 2'b00);
        st_be      = 4'b1111;
        st_data    = wdata;
      end
      default: ;
    endcase
  end

  // Load lane selection uses the opcode and byte offset latched at acceptance.
  always_comb begin
    case (lo_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_q)
      OP_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_ext = {24'h0, ld_byte};
      OP_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_ext = {16'h0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    lo_d        = lo_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    case (state_q)
      S_IDLE: begin
        if (req_rd || req_wr) begin
          if ((req_rd && req_wr) || (req_rd && !is_load) ||
              (req_wr && !is_store) || misaligned) begin
            state_d = S_ERR;
          end else begin
            op_d       = op;
            lo_d       = addr[1:0];
            mem_addr_d = {addr[31:2], 2'b00};
            if (req_rd) begin
              state_d  = S_RD_WAIT;
              mem_rd_d = 1'b1;
              mem_be_d = 4'b0000;
            end else begin
              state_d     = S_WR_WAIT;
              mem_wr_d    = 1'b1;
              mem_be_d    = st_be;
              mem_wdata_d = st_data;
            end
          end
        end
      end
      S_RD_WAIT: begin
        if (mem_ready) begin
          rdata_d  = ld_ext;
          mem_rd_d = 1'b0;
          state_d  = S_DONE;
        end else if (timeout) begin
          mem_rd_d = 1'b0;
          state_d  = S_ERR;
        end
      end
      S_WR_WAIT: begin
        if (mem_ready || timeout) begin
          mem_wr_d = 1'b0;
          mem_be_d = 4'b0000;
          state_d  = mem_ready ? S_DONE : S_ERR;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      lo_q        <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      lo_q        <= lo_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
    end
  end

  assign rdata     = rdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: scoreboard bench; stimulus pushes expected responses, monitors pop and compare.
`default_nettype none

module tb_dmem_access_unit;

  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24,
                         LHU = 6'h25, SB = 6'h28, SH = 6'h29, SW = 6'h2B;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_rd = 1'b0, req_wr = 1'b0;
  logic [5:0]  op = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic        done, err, busy, mem_rd, mem_wr;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  dmem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_rd(req_rd), .req_wr(req_wr), .op(op),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err),
    .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [31:0] rdata;
    int          cyc;
  } resp_t;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          hold;
  } mreq_t;

  resp_t resp_q[$];
  mreq_t mreq_q[$];

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int wait_cycles = 0;
  bit stuck = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: raises mem_ready after wait_cycles strobe cycles.
  int wcnt = 0;
  always @(negedge clk) begin
    if ((mem_rd || mem_wr) && !stuck) begin
      mem_ready = (wcnt == wait_cycles);
      wcnt++;
    end else begin
      mem_ready = 1'b0;
      wcnt = 0;
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (rst_n && (done || err)) begin
      if (resp_q.size() == 0) begin
        check("unexpected_pulse", {30'h0, err, done}, 32'h0);
      end else begin
        resp_t e;
        e = resp_q.pop_front();
        check("resp_kind", {30'h0, err, done}, e.is_err ? 32'h2 : 32'h1);
        check("resp_rdata", rdata, e.rdata);
        check("resp_cycle", cyc, e.cyc);
      end
    end
  end

  // Memory-side monitor: checks request fields on strobe rise, hold length on fall.
  bit    strobe_seen = 1'b0;
  int    hold_cnt = 0;
  mreq_t cur;
  always @(negedge clk) begin
    if (mem_rd || mem_wr) begin
      if (!strobe_seen) begin
        strobe_seen = 1'b1;
        hold_cnt = 0;
        if (mreq_q.size() == 0) begin
          check("unexpected_strobe", {30'h0, mem_wr, mem_rd}, 32'h0);
          cur.hold = -1;
        end else begin
          cur = mreq_q.pop_front();
          check("mem_kind", {30'h0, mem_wr, mem_rd}, cur.is_wr ? 32'h2 : 32'h1);
          check("mem_addr", mem_addr, cur.addr);
          check("mem_be", {28'h0, mem_be}, {28'h0, cur.be});
          if (cur.is_wr) check("mem_wdata", mem_wdata, cur.wdata);
        end
      end
      hold_cnt++;
    end else if (strobe_seen) begin
      strobe_seen = 1'b0;
      if (cur.hold >= 0) check("strobe_hold", hold_cnt, cur.hold);
    end
  end

  task automatic issue(input bit rd, input bit wr, input logic [5:0] o,
                       input logic [31:0] a, input logic [31:0] wd,
                       input bit exp_err, input logic [31:0] exp_rdata, input int lat);
    resp_t r;
    @(negedge clk);
    req_rd = rd; req_wr = wr; op = o; addr = a; wdata = wd;
    r.is_err = exp_err; r.rdata = exp_rdata; r.cyc = cyc + 1 + lat;
    if (lat >= 0) resp_q.push_back(r);
    @(negedge clk);
    req_rd = 1'b0; req_wr = 1'b0;
  endtask

  task automatic push_mem(input bit wr, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd, input int hold);
    mreq_t m;
    m.is_wr = wr; m.addr = a; m.be = be; m.wdata = wd; m.hold = hold;
    mreq_q.push_back(m);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((resp_q.size() != 0 || busy) && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", {31'h0, n == 64}, 32'h0);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_rdata", rdata, 32'h0);
    check("rst_outs", {26'h0, done, err, busy, mem_rd, mem_wr, |mem_be}, 32'h0);
    rst_n = 1'b1;

    // LB lane 3, zero-wait: sign-extended 0x80, done two edges after request.
    wait_cycles = 0; mem_rdata = 32'h80112233;
    push_mem(1'b0, 32'h100, 4'h0, 32'h0, 1);
    issue(1'b1, 1'b0, LB, 32'h103, 32'h0, 1'b0, 32'hFFFFFF80, 2);
    drain();

    // LHU upper half with 3 wait cycles.
    wait_cycles = 3; mem_rdata = 32'h9ABC1234;
    push_mem(1'b0, 32'h100, 4'h0, 32'h0, 4);
    issue(1'b1, 1'b0, LHU, 32'h102, 32'h0, 1'b0, 32'h00009ABC, 5);
    drain();

    // SB lane 1.
    wait_cycles = 0;
    push_mem(1'b1, 32'h200, 4'b0010, 32'hA5A5A5A5, 1);
    issue(1'b0, 1'b1, SB, 32'h201, 32'h000000A5, 1'b0, 32'h00009ABC, 2);
    drain();

    // SH upper half, one wait.
    wait_cycles = 1;
    push_mem(1'b1, 32'h100, 4'b1100, 32'hBEEFBEEF, 2);
    issue(1'b0, 1'b1, SH, 32'h102, 32'h1234BEEF, 1'b0, 32'h00009ABC, 3);
    drain();

    // Error cases: no strobe, rdata unchanged.
    issue(1'b0, 1'b1, SW, 32'h302, 32'h0, 1'b1, 32'h00009ABC, 1);
    drain();
    issue(1'b1, 1'b0, LH, 32'h101, 32'h0, 1'b1, 32'h00009ABC, 1);
    drain();
    issue(1'b1, 1'b1, LW, 32'h100, 32'h0, 1'b1, 32'h00009ABC, 1);
    drain();
    issue(1'b1, 1'b0, 6'h00, 32'h100, 32'h0, 1'b1, 32'h00009ABC, 1);
    drain();
    issue(1'b0, 1'b1, LB, 32'h100, 32'h0, 1'b1, 32'h00009ABC, 1);
    drain();

    // LH lower half sign-extended; LBU lane 1.
    wait_cycles = 0; mem_rdata = 32'h00008001;
    push_mem(1'b0, 32'h100, 4'h0, 32'h0, 1);
    issue(1'b1, 1'b0, LH, 32'h100, 32'h0, 1'b0, 32'hFFFF8001, 2);
    drain();
    mem_rdata = 32'h0000F700;
    push_mem(1'b0, 32'h100, 4'h0, 32'h0, 1);
    issue(1'b1, 1'b0, LBU, 32'h101, 32'h0, 1'b0, 32'h000000F7, 2);
    drain();

    // LW with waits; a store request while busy must be ignored.
    wait_cycles = 3; mem_rdata = 32'hDEADBEEF;
    push_mem(1'b0, 32'h104, 4'h0, 32'h0, 4);
    issue(1'b1, 1'b0, LW, 32'h104, 32'h0, 1'b0, 32'hDEADBEEF, 5);
    req_wr = 1'b1; op = SW; addr = 32'h400; wdata = 32'h11111111;
    @(negedge clk);
    req_wr = 1'b0;
    drain();

    // Reset during RD_WAIT: strobe drops at once, no response.
    stuck = 1'b1;
    push_mem(1'b0, 32'h10, 4'h0, 32'h0, 2);
    issue(1'b1, 1'b0, LW, 32'h10, 32'h0, 1'b0, 32'h0, -1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("midrst_outs", {28'h0, mem_rd, busy, done, err}, 32'h0);
    check("midrst_rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    stuck = 1'b0; wait_cycles = 0; mem_rdata = 32'h12345678;
    push_mem(1'b0, 32'h10, 4'h0, 32'h0, 1);
    issue(1'b1, 1'b0, LW, 32'h10, 32'h0, 1'b0, 32'h12345678, 2);
    drain();

    // mem_ready stuck low.
    stuck = 1'b1;
`ifdef MEM_TIMEOUT_EN
    push_mem(1'b0, 32'h20, 4'h0, 32'h0, 16);
    issue(1'b1, 1'b0, LW, 32'h20, 32'h0, 1'b1, 32'h12345678, 17);
    drain();
`else
    push_mem(1'b0, 32'h20, 4'h0, 32'h0, -1);
    issue(1'b1, 1'b0, LW, 32'h20, 32'h0, 1'b0, 32'h0, -1);
    repeat (40) @(negedge clk);
    check("stuck_busy", {30'h0, busy, mem_rd}, 32'h3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif
    stuck = 1'b0;
    repeat (3) @(negedge clk);
    check("resp_queue_empty", resp_q.size(), 32'h0);
    check("mem_queue_empty", mreq_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
